// File: rtl/leitor_7seg_bcd.sv
// Reads a multiplexed 4-digit 7-segment bus back into per-digit BCD registers.
// A digit commits after STABLE identical samples and its valid bit expires after TIMEOUT idle cycles.
module leitor_7seg_bcd #(
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd_digits,
  output logic [3:0]  valid,
  output logic [3:0]  err,
  output logic        upd
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int AW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Returns {decodable, value}; value is zero when the pattern is not a digit.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0111111: r = {1'b1, 4'd0};
      7'b0000110: r = {1'b1, 4'd1};
      7'b1011011: r = {1'b1, 4'd2};
      7'b1001111: r = {1'b1, 4'd3};
      7'b1100110: r = {1'b1, 4'd4};
      7'b1101101: r = {1'b1, 4'd5};
      7'b1111101: r = {1'b1, 4'd6};
      7'b0000111: r = {1'b1, 4'd7};
      7'b1111111: r = {1'b1, 4'd8};
      7'b1101111: r = {1'b1, 4'd9};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  state_t          state_r;
  logic [3:0]      cur_an_r;
  logic [6:0]      cur_seg_r;
  logic [CW-1:0]   cnt_r;
  logic [AW-1:0]   age_r [4];

  logic            sample_ok_s;
  logic            match_s;
  logic            commit_s;
  logic [4:0]      dec_s;
  logic [15:0]     bcd_n_s;
  logic [3:0]      valid_n_s;
  logic [3:0]      err_n_s;
  logic [AW-1:0]   age_n_s [4];

  // Commit detection and next-state of the per-digit output and age registers.
  always_comb begin
    sample_ok_s = onehot4(an);
    match_s     = (an == cur_an_r) && (seg == cur_seg_r);
    commit_s    = (state_r == TRACK) && sample_ok_s && match_s && (cnt_r == CW'(STABLE - 1));
    dec_s       = decode_seg(cur_seg_r);
    bcd_n_s     = bcd_digits;
    valid_n_s   = valid;
    err_n_s     = err;
    for (int i = 0; i < 4; i++) begin
      age_n_s[i] = age_r[i];
      if (commit_s && cur_an_r[i]) begin
        // A commit beats a timeout landing on the same edge.
        age_n_s[i]   = {AW{1'b0}};
        valid_n_s[i] = dec_s[4];
        err_n_s[i]   = ~dec_s[4];
        if (dec_s[4]) begin
          bcd_n_s[4*i +: 4] = dec_s[3:0];
        end else begin
          bcd_n_s[4*i +: 4] = bcd_digits[4*i +: 4];
        end
      end else begin
        if (age_r[i] >= AW'(TIMEOUT - 1)) begin
          valid_n_s[i] = 1'b0;
        end else begin
          valid_n_s[i] = valid[i];
        end
        if (age_r[i] == AW'(TIMEOUT)) begin
          age_n_s[i] = age_r[i];
        end else begin
          age_n_s[i] = age_r[i] + AW'(1);
        end
      end
    end
  end

  // Tracker FSM: counts identical one-hot samples until STABLE is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cur_an_r  <= 4'b0000;
      cur_seg_r <= 7'b0000000;
      cnt_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (sample_ok_s) begin
            cur_an_r  <= an;
            cur_seg_r <= seg;
            cnt_r     <= CW'(1);
            state_r   <= TRACK;
          end else begin
            state_r   <= IDLE;
          end
        end
        TRACK: begin
          if (!sample_ok_s) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else if (!match_s) begin
            cur_an_r  <= an;
            cur_seg_r <= seg;
            cnt_r     <= CW'(1);
            state_r   <= TRACK;
          end else if (cnt_r == CW'(STABLE - 1)) begin
            cnt_r   <= CW'(STABLE);
            state_r <= HELD;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= TRACK;
          end
        end
        HELD: begin
          if (!sample_ok_s) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else if (!match_s) begin
            cur_an_r  <= an;
            cur_seg_r <= seg;
            cnt_r     <= CW'(1);
            state_r   <= TRACK;
          end else begin
            state_r <= HELD;
          end
        end
        default: begin
          cnt_r   <= {CW{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output, age and update-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_digits <= 16'h0000;
      valid      <= 4'b0000;
      err        <= 4'b0000;
      upd        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        age_r[i] <= {AW{1'b0}};
      end
    end else begin
      bcd_digits <= bcd_n_s;
      valid      <= valid_n_s;
      err        <= err_n_s;
      upd        <= (bcd_n_s != bcd_digits) || (valid_n_s != valid) || (err_n_s != err);
      for (int i = 0; i < 4; i++) begin
        age_r[i] <= age_n_s[i];
      end
    end
  end

endmodule

// File: tb/tb_leitor_7seg_bcd.sv
// Self-checking bench for leitor_7seg_bcd: directed scenarios plus random bus traffic
// compared every cycle against a run-length / timestamp reference model.
module tb_leitor_7seg_bcd;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  an  = 4'd0;
  logic [15:0] bcd_digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;

  leitor_7seg_bcd #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .bcd_digits(bcd_digits), .valid(valid), .err(err), .upd(upd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Reference model state
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          run;
  longint      cyc;
  longint      last [4];
  bit          ok [4];
  bit          eb [4];
  logic [3:0]  val [4];
  logic [15:0] exp_bcd;
  logic [3:0]  exp_valid, exp_err;
  logic        exp_upd;

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    run = 0; cyc = 0; m_an = 4'd0; m_seg = 7'd0;
    for (int i = 0; i < 4; i++) begin
      last[i] = 0; ok[i] = 1'b0; eb[i] = 1'b0; val[i] = 4'd0;
    end
    exp_bcd = 16'h0000; exp_valid = 4'd0; exp_err = 4'd0; exp_upd = 1'b0;
  endtask

  task automatic model_outputs(output logic [15:0] b, output logic [3:0] v, output logic [3:0] e);
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = val[i];
      v[i] = ok[i] && ((cyc - last[i]) < TIMEOUT);
      e[i] = eb[i];
    end
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    logic [15:0] pb;
    logic [3:0]  pv, pe;
    int d, idx;
    model_outputs(pb, pv, pe);
    cyc++;
    if ($countones(a) == 1) begin
      if (run > 0 && a == m_an && s == m_seg) run++;
      else begin
        m_an = a; m_seg = s; run = 1;
      end
      if (run == STABLE) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (a[k]) idx = k;
        d = decode(s);
        if (d >= 0) begin
          val[idx] = d[3:0]; ok[idx] = 1'b1; eb[idx] = 1'b0;
        end else begin
          ok[idx] = 1'b0; eb[idx] = 1'b1;
        end
        last[idx] = cyc;
      end
    end else begin
      run = 0;
    end
    model_outputs(exp_bcd, exp_valid, exp_err);
    exp_upd = ({exp_bcd, exp_valid, exp_err} != {pb, pv, pe});
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd_digits", bcd_digits, exp_bcd);
      check("valid", {12'd0, valid}, {12'd0, exp_valid});
      check("err", {12'd0, err}, {12'd0, exp_err});
      check("upd", {15'd0, upd}, {15'd0, exp_upd});
    end
  end

  task automatic tick(input logic [3:0] a, input logic [6:0] s);
    an = a; seg = s;
    @(posedge clk);
    if (!rst) model_step(a, s);
    #1;
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, output int p);
    p = 0;
    for (int k = 0; k < n; k++) begin
      tick(a, s);
      p += int'(upd);
    end
  endtask

  int p, n;
  logic [3:0] ra;
  logic [6:0] rs;
  int r;

  initial begin
    model_reset();
    rst = 1'b1;
    hold(4'd0, 7'd0, 3, p);
    check("reset_bcd", bcd_digits, 16'h0000);
    check("reset_valid", {12'd0, valid}, 16'h0000);
    check("reset_err", {12'd0, err}, 16'h0000);
    check("reset_upd", {15'd0, upd}, 16'h0000);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single digit commit on the 4th edge
    hold(4'b0001, 7'b1011011, 3, p);
    check("d0_no_early", {12'd0, valid}, 16'h0000);
    hold(4'b0001, 7'b1011011, 1, p);
    check("d0_value", {12'd0, bcd_digits[3:0]}, 16'h0002);
    check("d0_valid", {12'd0, valid}, 16'h0001);
    check("d0_upd", 16'(p), 16'd1);
    hold(4'b0001, 7'b1011011, 6, p);
    check("d0_hold_no_upd", 16'(p), 16'd0);

    // Scan 7,3,9,0
    n = 0;
    hold(4'b0001, 7'b0000111, 4, p); n += p;
    hold(4'b0010, 7'b1001111, 4, p); n += p;
    hold(4'b0100, 7'b1101111, 4, p); n += p;
    hold(4'b1000, 7'b0111111, 4, p); n += p;
    check("scan_bcd", bcd_digits, 16'h0937);
    check("scan_valid", {12'd0, valid}, 16'h000f);
    check("scan_upd", 16'(n), 16'd4);

    // Glitch restarts the count
    hold(4'b0100, 7'b1101101, 3, p);
    hold(4'b0100, 7'b1111101, 1, p);
    hold(4'b0100, 7'b1101101, 3, p);
    check("glitch_no_commit", {12'd0, bcd_digits[11:8]}, 16'h0009);
    hold(4'b0100, 7'b1101101, 1, p);
    check("glitch_commit", {12'd0, bcd_digits[11:8]}, 16'h0005);

    // Error glyph keeps the value, flags err
    hold(4'b0010, 7'b1111111, 4, p);
    hold(4'b0010, 7'b0001110, 4, p);
    check("errglyph_err", {15'd0, err[1]}, 16'd1);
    check("errglyph_valid", {15'd0, valid[1]}, 16'd0);
    check("errglyph_bcd", {12'd0, bcd_digits[7:4]}, 16'h0008);

    // Non-one-hot selects never commit
    n = 0;
    hold(4'b0011, 7'b0000110, 10, p); n += p;
    hold(4'b0000, 7'b0000110, 10, p); n += p;
    check("nonhot_upd", 16'(n), 16'd0);
    check("nonhot_bcd", bcd_digits, 16'h0587);
    check("nonhot_valid", {12'd0, valid}, 16'h000d);
    check("nonhot_err", {12'd0, err}, 16'h0002);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       ra = 4'b0001 << $urandom_range(0, 3);
      else if (r == 8) ra = 4'b0000;
      else             ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rs = 7'($urandom);
      else                           rs = pat[$urandom_range(0, 9)];
      hold(ra, rs, $urandom_range(1, 6), p);
    end

    // Timeout: re-commit on the TIMEOUT edge, then let it expire
    hold(4'b0001, 7'b1100110, 4, p);
    hold(4'b0000, 7'b0000000, TIMEOUT - 4, p);
    hold(4'b0001, 7'b1100110, 3, p);
    check("to_before", {15'd0, valid[0]}, 16'd1);
    hold(4'b0001, 7'b1100110, 1, p);
    check("to_recommit_valid", {15'd0, valid[0]}, 16'd1);
    check("to_recommit_upd", 16'(p), 16'd0);
    hold(4'b0000, 7'b0000000, TIMEOUT - 1, p);
    check("to_not_yet", {15'd0, valid[0]}, 16'd1);
    hold(4'b0000, 7'b0000000, 1, p);
    check("to_expired", {15'd0, valid[0]}, 16'd0);
    check("to_upd", 16'(p), 16'd1);
    check("to_value_kept", {12'd0, bcd_digits[3:0]}, 16'h0004);

    // Async reset mid-track discards the partial count
    hold(4'b0100, 7'b0000110, 2, p);
    rst = 1'b1;
    #1;
    check("arst_bcd", bcd_digits, 16'h0000);
    check("arst_valid", {12'd0, valid}, 16'h0000);
    check("arst_err", {12'd0, err}, 16'h0000);
    check("arst_upd", {15'd0, upd}, 16'h0000);
    model_reset();
    hold(4'b0100, 7'b0000110, 1, p);
    rst = 1'b0;
    hold(4'b0100, 7'b0000110, 3, p);
    check("arst_no_early", bcd_digits, 16'h0000);
    hold(4'b0100, 7'b0000110, 1, p);
    check("arst_commit", bcd_digits, 16'h0100);
    hold(4'b0000, 7'b0000000, 2, p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/leitor_7seg_bcd.md
# leitor_7seg_bcd

Sequential 7-segment-to-BCD reader: samples a multiplexed 4-digit 7-segment display bus (segment lines plus one-hot digit select), waits for each digit's pattern to hold steady, decodes it back to BCD and keeps one register per digit. It is the inverse end of the BCD-to-7-segment display path. Uses: self-checking the display driver, loop-back tests, and reading the display from board-level logic. Digits that stop being refreshed expire after a timeout.

## Interface
- STABLE, 4: consecutive identical samples (same `an`, same `seg`) required before a digit is committed; legal range ≥2.
- TIMEOUT, 1024: cycles without a commit after which a digit's `valid` bit clears; legal range ≥ 4·STABLE.
- clk  input  1  single clock; every register updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg  input  7  segment levels, active-high. Bit 0 = a … bit 6 = g. Example: "0" = 7'b0111111.
- an  input  4  digit select, active-high; bit i selects digit i. Only one-hot values are meaningful.
- bcd_digits  output  16  digit i occupies bits [4i+3:4i].
- valid  output  4  bit i is 1 when digit i holds a decoded value that has not expired.
- err  output  4  bit i is 1 when the last commit of digit i was an undecodable pattern.
- upd  output  1  one-cycle pulse on every edge that changes `bcd_digits`, `valid` or `err`.

## Operation
- Decode table (seg → value):
  - 0111111 → 0, 0000110 → 1, 1011011 → 2, 1001111 → 3, 1100110 → 4.
  - 1101101 → 5, 1111101 → 6, 0000111 → 7, 1111111 → 8, 1101111 → 9.
  - Any other pattern is undecodable. This includes the error glyph 7'b0001110 and the blank pattern 0000000.
- Tracker registers: `cur_an`, `cur_seg`, and a count `cnt` (0..STABLE, saturating).
- Tracker state machine, evaluated on each edge:
  - IDLE:
    - `an` one-hot → load `cur_an`/`cur_seg`, set `cnt`=1, go to TRACK.
    - Otherwise stay in IDLE.
  - TRACK:
    - `an` not one-hot → `cnt`=0, go to IDLE.
    - Sample differs from `cur_an`/`cur_seg` → reload the tracker, `cnt`=1, stay in TRACK.
    - Sample matches → `cnt`+1. When `cnt` reaches STABLE, commit and go to HELD.
  - HELD:
    - Matching sample → stay in HELD. No further commits.
    - `an` not one-hot → go to IDLE.
    - Different one-hot sample → reload the tracker, `cnt`=1, go to TRACK.
- Commit of digit i:
  - Decodable pattern → `bcd_digits[i]` = value, `valid[i]`=1, `err[i]`=0.
  - Undecodable pattern → `bcd_digits[i]` unchanged, `valid[i]`=0, `err[i]`=1.
  - In both cases `age[i]` = 0.
- Age counters, one per digit:
  - `age[i]` increments every cycle and saturates at TIMEOUT.
  - When `age[i]` reaches TIMEOUT, `valid[i]` clears. `bcd_digits[i]` and `err[i]` are retained.
- Simultaneous events:
  - A commit and a timeout on the same digit in the same edge: the commit wins.
  - A commit on digit i and a timeout on digit j: both apply in the same edge.
- Re-committing an identical value still resets `age` and re-enters HELD. It does not pulse `upd` unless an output actually changes.

## Timing
- Reset values: `bcd_digits`=16'h0000, `valid`=4'b0000, `err`=4'b0000, `upd`=0. Tracker goes to IDLE with `cnt`=0; all `age`=0.
- Reset is asynchronous. Asserting it mid-track discards the partial count, and outputs go to reset values immediately.
- Latency: let the first edge sampling a new stable pair be edge 1. The commit takes effect at edge STABLE, so outputs and `upd` are visible after edge STABLE (edge 4 with the defaults).
- `upd` is registered. It is high in exactly the cycle following each output-changing edge.
- Input glitches:
  - A one-cycle change in `seg` or `an` restarts the count.
  - Holding a pattern for STABLE-1 cycles never commits.
- A digit refreshed at least every TIMEOUT-1 cycles never expires.

## Test plan
- Reset, then `an`=0001 and `seg`=1011011 held for 4 cycles → after edge 4: `bcd_digits[3:0]`=2, `valid`=0001, `err`=0000, `upd` pulses once. Holding the inputs longer produces no further `upd`.
- Scan digits 0..3 with patterns for 7, 3, 9, 0, each held 4 cycles → `bcd_digits`=16'h0937, `valid`=1111, 4 `upd` pulses.
- `an`=0100 with 1101101 held for 3 cycles, then a 1-cycle glitch on `seg`, then held 4 more cycles → no commit before the post-glitch 4th edge; then digit 2 = 5.
- `an`=0010 with the error glyph 0001110 held 4 cycles after digit 1 = 8 → `err[1]`=1, `valid[1]`=0, `bcd_digits[7:4]` stays 8.
- `an`=0011 (not one-hot) held for 10 cycles, and `an`=0000 held for 10 cycles → no commits, outputs unchanged.
- Commit digit 0 = 4, then stop driving it for 1024 cycles → `valid[0]` clears at the TIMEOUT edge, `upd` pulses, digit value stays 4. A re-commit arriving on the TIMEOUT edge keeps `valid[0]`=1. Asserting `rst` mid-count returns all outputs to reset values.
